// File: rtl/issue_scoreboard.sv
// Issue scoreboard: in-flight tag window plus per-register busy/owner tracking
// between decode and execute. Issues only hazard-free instructions into free tags.
module issue_scoreboard #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned TAG_W     = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             rdy_in,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic             rs1_request_i,
  input  logic [4:0]       rs1_addr_i,
  input  logic             rs2_request_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic             rd_write_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             ex_ready_i,
  output logic             issue_valid_o,
  output logic [TAG_W-1:0] issue_tag_o,
  input  logic             wb_valid_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [TAG_W:0]   inflight_o
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = TAG_W + 1;

  logic [NREGS-1:0]     busy_q,      busy_d;
  logic [TAG_W-1:0]     owner_q     [NREGS];
  logic [TAG_W-1:0]     owner_d     [NREGS];
  logic [NUM_SLOTS-1:0] slot_used_q, slot_used_d;
  logic [REG_W-1:0]     slot_rd_q   [NUM_SLOTS];
  logic [REG_W-1:0]     slot_rd_d   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_wr_q,   slot_wr_d;
  logic [CNT_W-1:0]     inflight_q,  inflight_d;

  logic                 hazard_c;
  logic                 full_c;
  logic                 fire_c;
  logic                 rd_valid_c;
  logic [TAG_W-1:0]     free_tag_c;

  // Lowest-index free slot from registered occupancy (freed tags reusable next cycle)
  always_comb begin
    free_tag_c = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!slot_used_q[i]) free_tag_c = TAG_W'(i);
    end
  end

  // RAW hazard and acceptance; x0 never blocks, writeback is not bypassed
  assign hazard_c   = (rs1_request_i && (rs1_addr_i != '0) && busy_q[rs1_addr_i]) ||
                      (rs2_request_i && (rs2_addr_i != '0) && busy_q[rs2_addr_i]);
  assign full_c     = &slot_used_q;
  assign id_ready_o = rdy_in & ex_ready_i & ~hazard_c & ~full_c & ~flush_i;
  assign fire_c     = id_valid_i & id_ready_o;
  assign rd_valid_c = rd_write_i && (rd_addr_i != '0);

  assign issue_valid_o = fire_c;
  assign issue_tag_o   = free_tag_c;
  assign stall_o       = id_valid_i & ~id_ready_o;
  assign inflight_o    = inflight_q;

  // Next state: flush wipes everything, else retire writeback then apply issue (issue wins)
  always_comb begin
    busy_d      = busy_q;
    owner_d     = owner_q;
    slot_used_d = slot_used_q;
    slot_rd_d   = slot_rd_q;
    slot_wr_d   = slot_wr_q;
    inflight_d  = '0;

    if (flush_i) begin
      busy_d      = '0;
      slot_used_d = '0;
      slot_wr_d   = '0;
    end else begin
      if (wb_valid_i && slot_used_q[wb_tag_i]) begin
        slot_used_d[wb_tag_i] = 1'b0;
        if (slot_wr_q[wb_tag_i] && (owner_q[slot_rd_q[wb_tag_i]] == wb_tag_i)) begin
          busy_d[slot_rd_q[wb_tag_i]] = 1'b0;
        end
      end
      if (fire_c) begin
        slot_used_d[free_tag_c] = 1'b1;
        slot_rd_d[free_tag_c]   = rd_addr_i;
        slot_wr_d[free_tag_c]   = rd_valid_c;
        if (rd_valid_c) begin
          busy_d[rd_addr_i]  = 1'b1;
          owner_d[rd_addr_i] = free_tag_c;
        end
      end
    end

    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      inflight_d = inflight_d + CNT_W'(slot_used_d[i]);
    end
  end

  // State registers; reset discards all in-flight tracking immediately
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      owner_q     <= '{default: '0};
      slot_used_q <= '0;
      slot_rd_q   <= '{default: '0};
      slot_wr_q   <= '0;
      inflight_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      slot_used_q <= slot_used_d;
      slot_rd_q   <= slot_rd_d;
      slot_wr_q   <= slot_wr_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, WAW, full window, flush, x0, reset.
module tb_issue_scoreboard;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       rdy_in;
  logic       id_valid_i;
  logic       id_ready_o;
  logic       rs1_request_i;
  logic [4:0] rs1_addr_i;
  logic       rs2_request_i;
  logic [4:0] rs2_addr_i;
  logic       rd_write_i;
  logic [4:0] rd_addr_i;
  logic       ex_ready_i;
  logic       issue_valid_o;
  logic [1:0] issue_tag_o;
  logic       wb_valid_i;
  logic [1:0] wb_tag_i;
  logic       flush_i;
  logic       stall_o;
  logic [2:0] inflight_o;

  int n_cmp = 0;
  int n_err = 0;

  issue_scoreboard #(.NUM_SLOTS(4), .TAG_W(2)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .rdy_in        (rdy_in),
    .id_valid_i    (id_valid_i),
    .id_ready_o    (id_ready_o),
    .rs1_request_i (rs1_request_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_request_i (rs2_request_i),
    .rs2_addr_i    (rs2_addr_i),
    .rd_write_i    (rd_write_i),
    .rd_addr_i     (rd_addr_i),
    .ex_ready_i    (ex_ready_i),
    .issue_valid_o (issue_valid_o),
    .issue_tag_o   (issue_tag_o),
    .wb_valid_i    (wb_valid_i),
    .wb_tag_i      (wb_tag_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .inflight_o    (inflight_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid_i    = 1'b0;
    rs1_request_i = 1'b0;
    rs1_addr_i    = '0;
    rs2_request_i = 1'b0;
    rs2_addr_i    = '0;
    rd_write_i    = 1'b0;
    rd_addr_i     = '0;
    wb_valid_i    = 1'b0;
    wb_tag_i      = '0;
    flush_i       = 1'b0;
  endtask

  task automatic instr(input logic r1q, input logic [4:0] r1, input logic r2q,
                       input logic [4:0] r2, input logic wr, input logic [4:0] rd);
    id_valid_i    = 1'b1;
    rs1_request_i = r1q;
    rs1_addr_i    = r1;
    rs2_request_i = r2q;
    rs2_addr_i    = r2;
    rd_write_i    = wr;
    rd_addr_i     = rd;
  endtask

  task automatic wb(input logic [1:0] tag);
    wb_valid_i = 1'b1;
    wb_tag_i   = tag;
  endtask

  // Inputs change on the falling edge; checks land 1 time unit later
  task automatic nxt();
    @(negedge clk_in);
    idle();
  endtask

  initial begin
    rst_n      = 1'b0;
    rdy_in     = 1'b1;
    ex_ready_i = 1'b1;
    idle();

    // Reset state
    #12;
    chk("rst_inflight", 32'(inflight_o), 0);
    chk("rst_ready", 32'(id_ready_o), 1);
    chk("rst_stall", 32'(stall_o), 0);
    @(negedge clk_in);
    rst_n = 1'b1;

    // 1: RAW stall until writeback, issue the cycle after the wb edge
    nxt(); instr(1, 5'd1, 0, 5'd0, 1, 5'd5); #1;
    chk("t1_ready", 32'(id_ready_o), 1);
    chk("t1_fire", 32'(issue_valid_o), 1);
    chk("t1_tag", 32'(issue_tag_o), 0);
    nxt(); instr(1, 5'd5, 1, 5'd1, 1, 5'd6); #1;
    chk("t1_infl1", 32'(inflight_o), 1);
    chk("t1_stall", 32'(stall_o), 1);
    chk("t1_nofire", 32'(issue_valid_o), 0);
    nxt(); instr(1, 5'd5, 1, 5'd1, 1, 5'd6); wb(2'd0); #1;
    chk("t1_nobypass", 32'(stall_o), 1);
    nxt(); instr(1, 5'd5, 1, 5'd1, 1, 5'd6); #1;
    chk("t1_unstall", 32'(stall_o), 0);
    chk("t1_fire2", 32'(issue_valid_o), 1);
    chk("t1_tag2", 32'(issue_tag_o), 0);
    chk("t1_infl0", 32'(inflight_o), 0);
    nxt(); wb(2'd0); #1;
    chk("t1_infl_b", 32'(inflight_o), 1);
    nxt(); #1;
    chk("t1_clean", 32'(inflight_o), 0);

    // 2: WAW, older writeback leaves register busy
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd5); #1;
    chk("t2_tag0", 32'(issue_tag_o), 0);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd5); #1;
    chk("t2_fire1", 32'(issue_valid_o), 1);
    chk("t2_tag1", 32'(issue_tag_o), 1);
    nxt(); wb(2'd0); #1;
    chk("t2_infl2", 32'(inflight_o), 2);
    nxt(); instr(1, 5'd5, 0, 5'd0, 1, 5'd7); #1;
    chk("t2_waw_stall", 32'(stall_o), 1);
    chk("t2_infl1", 32'(inflight_o), 1);
    nxt(); instr(1, 5'd5, 0, 5'd0, 1, 5'd7); wb(2'd1); #1;
    chk("t2_stall_wb", 32'(stall_o), 1);
    nxt(); instr(1, 5'd5, 0, 5'd0, 1, 5'd7); #1;
    chk("t2_fire_rd", 32'(issue_valid_o), 1);
    chk("t2_tag_rd", 32'(issue_tag_o), 0);
    nxt(); wb(2'd0); #1;
    chk("t2_infl_rd", 32'(inflight_o), 1);
    nxt(); #1;
    chk("t2_clean", 32'(inflight_o), 0);

    // 7: issue and wb on same rd in one cycle, issue keeps it busy
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd20); #1;
    chk("t7_tag0", 32'(issue_tag_o), 0);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd20); wb(2'd0); #1;
    chk("t7_tag1", 32'(issue_tag_o), 1);
    chk("t7_fire", 32'(issue_valid_o), 1);
    nxt(); instr(1, 5'd20, 0, 5'd0, 1, 5'd21); #1;
    chk("t7_busy", 32'(stall_o), 1);
    chk("t7_infl", 32'(inflight_o), 1);
    nxt(); instr(1, 5'd20, 0, 5'd0, 1, 5'd21); wb(2'd1); #1;
    chk("t7_busy_wb", 32'(stall_o), 1);
    nxt(); instr(1, 5'd20, 0, 5'd0, 1, 5'd21); #1;
    chk("t7_fire_rd", 32'(issue_valid_o), 1);
    chk("t7_tag_rd", 32'(issue_tag_o), 0);
    nxt(); wb(2'd0);
    nxt(); #1;
    chk("t7_clean", 32'(inflight_o), 0);

    // 3: full window, freed tag reused next cycle
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd10); #1;
    chk("t3_tag0", 32'(issue_tag_o), 0);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd11); #1;
    chk("t3_tag1", 32'(issue_tag_o), 1);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd12); #1;
    chk("t3_tag2", 32'(issue_tag_o), 2);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd13); #1;
    chk("t3_tag3", 32'(issue_tag_o), 3);
    chk("t3_fire3", 32'(issue_valid_o), 1);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd14); wb(2'd2); #1;
    chk("t3_infl4", 32'(inflight_o), 4);
    chk("t3_full", 32'(id_ready_o), 0);
    chk("t3_full_stall", 32'(stall_o), 1);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd14); #1;
    chk("t3_reuse_rdy", 32'(id_ready_o), 1);
    chk("t3_reuse_tag", 32'(issue_tag_o), 2);
    chk("t3_infl3", 32'(inflight_o), 3);
    nxt(); #1;
    chk("t3_infl4b", 32'(inflight_o), 4);
    nxt(); flush_i = 1'b1; #1;
    chk("t3_flush_rdy", 32'(id_ready_o), 0);
    nxt(); #1;
    chk("t3_flushed", 32'(inflight_o), 0);

    // 4: flush with 3 in flight, stale wb ignored
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd5); #1;
    chk("t4_tag0", 32'(issue_tag_o), 0);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd6); #1;
    chk("t4_tag1", 32'(issue_tag_o), 1);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd7); #1;
    chk("t4_tag2", 32'(issue_tag_o), 2);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd8); flush_i = 1'b1; #1;
    chk("t4_infl3", 32'(inflight_o), 3);
    chk("t4_nofire", 32'(issue_valid_o), 0);
    nxt(); wb(2'd1); #1;
    chk("t4_infl0", 32'(inflight_o), 0);
    nxt(); #1;
    chk("t4_stale", 32'(inflight_o), 0);
    nxt(); instr(1, 5'd5, 1, 5'd7, 1, 5'd9); #1;
    chk("t4_busy_clr", 32'(id_ready_o), 1);
    chk("t4_tag", 32'(issue_tag_o), 0);
    nxt(); wb(2'd0);
    nxt(); #1;
    chk("t4_clean", 32'(inflight_o), 0);

    // 5: x0 reads/writes never stall
    nxt(); instr(1, 5'd0, 1, 5'd0, 1, 5'd0); #1;
    chk("t5_tag0", 32'(issue_tag_o), 0);
    nxt(); instr(1, 5'd0, 1, 5'd0, 1, 5'd0); #1;
    chk("t5_nostall1", 32'(stall_o), 0);
    chk("t5_tag1", 32'(issue_tag_o), 1);
    nxt(); instr(1, 5'd0, 1, 5'd0, 1, 5'd0); #1;
    chk("t5_nostall2", 32'(stall_o), 0);
    chk("t5_tag2", 32'(issue_tag_o), 2);
    nxt(); flush_i = 1'b1;
    nxt(); #1;
    chk("t5_clean", 32'(inflight_o), 0);

    // 6: async reset mid-flight, readiness follows ex_ready & rdy
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd5); #1;
    chk("t6_tag0", 32'(issue_tag_o), 0);
    nxt(); instr(0, 5'd0, 0, 5'd0, 1, 5'd6); #1;
    chk("t6_tag1", 32'(issue_tag_o), 1);
    nxt(); #1;
    chk("t6_infl2", 32'(inflight_o), 2);
    rst_n = 1'b0; #1;
    chk("t6_rst_infl", 32'(inflight_o), 0);
    chk("t6_rst_rdy", 32'(id_ready_o), 1);
    rdy_in = 1'b0; #1;
    chk("t6_rdy0", 32'(id_ready_o), 0);
    rdy_in = 1'b1; ex_ready_i = 1'b0; #1;
    chk("t6_ex0", 32'(id_ready_o), 0);
    ex_ready_i = 1'b1; #1;
    chk("t6_both1", 32'(id_ready_o), 1);
    nxt(); rst_n = 1'b1;
    nxt(); instr(1, 5'd5, 1, 5'd6, 1, 5'd7); #1;
    chk("t6_post_fire", 32'(issue_valid_o), 1);
    chk("t6_post_tag", 32'(issue_tag_o), 0);
    nxt(); rdy_in = 1'b0; instr(0, 5'd0, 0, 5'd0, 0, 5'd0); #1;
    chk("t6_rdy_block", 32'(stall_o), 1);
    chk("t6_infl1", 32'(inflight_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
